tlb_refill_walker: RTL
======================

Name: tlb_refill_walker

Overview:
- Hardware page-table walker that services TLB misses for the 8-entry TLB.
- Takes a missing 20-bit VPN and performs a two-level page-table walk over a simple req/ack memory port.
- On success, issues a one-cycle tlbwr with the 24-bit PTE and its VPN into the TLB write port (pte_in/vpn/tlbwr).
- Reports a fault on an invalid entry or a memory timeout.

Parameters:
TIMEOUT, 255, maximum cycles mem_req may stay high per level before a timeout fault (range 1..255).

Ports:
clk  in  1  clock, all state updates on rising edge
clr  in  1  asynchronous active-high reset
miss  in  1  TLB miss request, sampled only in IDLE
vpn_miss  in  20  missing virtual page number
ptbr  in  20  page-directory base frame number
abort  in  1  cancel walk, return to IDLE
mem_req  out  1  memory read request
mem_addr  out  32  memory byte address
mem_ack  in  1  memory read data valid
mem_rdata  in  32  memory read data
tlbwr  out  1  one-cycle TLB random-write strobe
pte_out  out  24  PTE to TLB pte_in
vpn_out  out  20  VPN to TLB vpn during write
busy  out  1  walk in progress
fault  out  1  one-cycle fault pulse
fault_code  out  2  01 L1 invalid, 10 L2 invalid, 11 timeout; held until next accepted miss

Behaviour:
- Reset (clr=1, async): state IDLE; all outputs 0; internal vpn, pde and counter registers cleared.
- Entry format, both levels, from mem_rdata: bit 23 = V, bits [19:0] = frame. PTE = mem_rdata[23:0].
- Address generation:
  - L1 address = {ptbr, vpn[19:10], 2'b00}.
  - L2 address = {pde[19:0], vpn[9:0], 2'b00}.
- States and transitions:
  - IDLE: miss=1 latches vpn_miss, clears fault_code, goes to L1.
  - L1: mem_req=1 and mem_addr = L1 address.
    - mem_ack with V=1: latch pde, go to L2.
    - mem_ack with V=0: go to FAULT, code 01.
  - L2: same handshake at the L2 address.
    - mem_ack with V=1: latch pte, go to WRITE.
    - mem_ack with V=0: go to FAULT, code 10.
  - WRITE: tlbwr=1 for exactly one cycle; then IDLE.
  - FAULT: fault=1 for exactly one cycle; then IDLE.
- Memory handshake:
  - mem_req and mem_addr are registered and stable while mem_req=1.
  - The transfer completes on the edge where mem_ack=1; data is sampled on that same edge.
  - mem_req drops in the following cycle unless the next level starts.
  - mem_ack while mem_req=0 is ignored.
- Timeout:
  - A per-level counter is cleared on entry to L1/L2 and increments each cycle mem_req=1 without ack.
  - If no ack arrives in TIMEOUT cycles, go to FAULT with code 11.
  - An ack in the TIMEOUT-th cycle counts as success.
- Latency with zero-wait memory (ack in the same cycle as req): miss sampled at edge E0; L1 ack at E1; L2 ack at E2; tlbwr high between E2 and E3.
- Each memory wait cycle adds one cycle to the latency.
- pte_out and vpn_out are registered:
  - valid and stable whenever tlbwr=1;
  - hold their last written values afterwards.
- busy=1 in L1, L2, WRITE and FAULT; busy=0 in IDLE.
- miss while busy is ignored and is not queued.
- abort:
  - In L1/L2: the next state is IDLE, mem_req drops next cycle, and any same-cycle ack and its data are discarded. No tlbwr, no fault.
  - In WRITE/FAULT: no effect; the pulse completes.
  - abort has priority over miss in IDLE.
- vpn_miss and ptbr are sampled only on miss acceptance (ptbr is used live in L1 only, so it must be stable while busy).

Test Plan:
1. Reset: assert clr mid-L2 with mem_req=1 -> all outputs 0 immediately (asynchronously), state IDLE; after release, a new miss walks normally.
2. Zero-wait walk: ptbr=0x00100, miss with vpn_miss=0x80005.
   - L1: mem_addr=0x00100800, rdata=0x00800123.
   - L2: mem_addr=0x00123014, rdata=0x00ff0005.
   - Result: tlbwr=1 in the third cycle after the miss edge, pte_out=0xff0005, vpn_out=0x80005, fault=0.
3. Wait states: same as test 2 but ack delayed 3 cycles at each level -> mem_addr holds 0x00100800 for 4 cycles, then 0x00123014 for 4 cycles; tlbwr 6 cycles later than in test 2; a second miss during busy is ignored.
4. L1 invalid: L1 rdata=0x00000123 -> no L2 request, fault pulse one cycle, fault_code=01, tlbwr never asserted. Repeat with L2 rdata=0x007f0005 -> fault_code=10.
5. Timeout: TIMEOUT=8, ack never asserted -> mem_req high exactly 8 cycles, then fault pulse, fault_code=11, busy=0 next cycle. A separate run with ack in cycle 8 completes the walk.
6. Abort: abort asserted in L2 together with mem_ack -> no tlbwr, no fault, mem_req=0 next cycle, pte_out unchanged from its previous value.

Source files
------------

// File: rtl/tlb_refill_walker.sv
// Two-level hardware page-table walker that refills the 8-entry TLB on a miss.
// Each level issues one req/ack memory read; valid entries advance the walk, invalid ones or timeouts fault.
module tlb_refill_walker #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        miss,
    input  logic [19:0] vpn_miss,
    input  logic [19:0] ptbr,
    input  logic        abort,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        tlbwr,
    output logic [23:0] pte_out,
    output logic [19:0] vpn_out,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [2:0] {IDLE, L1, L2, WRITE, FAULT} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state;
    logic [19:0] vpn;
    logic [19:0] pde;
    logic [7:0]  wait_cnt;
    logic        entry_valid;
    logic        unused_rdata_bits;

    assign entry_valid       = mem_rdata[23];
    assign unused_rdata_bits = ^mem_rdata[31:24];

    // The address is a pure function of the walk state, so it holds steady for as long as mem_req is high.
    // ptbr is read live while in L1 and must therefore stay stable throughout a walk.
    always_comb begin
        mem_addr = 32'h0;
        case (state)
            L1:      mem_addr = {ptbr, vpn[19:10], 2'b00};
            L2:      mem_addr = {pde, vpn[9:0], 2'b00};
            default: mem_addr = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            vpn        <= '0;
            pde        <= '0;
            wait_cnt   <= '0;
            mem_req    <= 1'b0;
            tlbwr      <= 1'b0;
            pte_out    <= '0;
            vpn_out    <= '0;
            busy       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    tlbwr <= 1'b0;
                    fault <= 1'b0;
                    if (miss && !abort) begin
                        vpn        <= vpn_miss;
                        fault_code <= 2'b00;
                        wait_cnt   <= '0;
                        mem_req    <= 1'b1;
                        busy       <= 1'b1;
                        state      <= L1;
                    end
                end
                L1: begin
                    // An abort wins over a same-cycle ack; the returned data is simply dropped.
                    if (abort) begin
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (mem_ack) begin
                        wait_cnt <= '0;
                        if (entry_valid) begin
                            pde   <= mem_rdata[19:0];
                            state <= L2;
                        end else begin
                            mem_req    <= 1'b0;
                            fault      <= 1'b1;
                            fault_code <= 2'b01;
                            state      <= FAULT;
                        end
                    end else if (wait_cnt == LAST_WAIT) begin
                        mem_req    <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= 2'b11;
                        state      <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                L2: begin
                    if (abort) begin
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (mem_ack) begin
                        mem_req  <= 1'b0;
                        wait_cnt <= '0;
                        if (entry_valid) begin
                            pte_out <= mem_rdata[23:0];
                            vpn_out <= vpn;
                            tlbwr   <= 1'b1;
                            state   <= WRITE;
                        end else begin
                            fault      <= 1'b1;
                            fault_code <= 2'b10;
                            state      <= FAULT;
                        end
                    end else if (wait_cnt == LAST_WAIT) begin
                        mem_req    <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= 2'b11;
                        state      <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                WRITE: begin
                    tlbwr <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                FAULT: begin
                    fault <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    tlbwr   <= 1'b0;
                    fault   <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
